arm_dmem_responder: RTL and testbench

- Data-memory responder on the far side of the pipeline's MEM-stage memory port.
- Accepts word addresses, reversed-order byte-lane write enables and store data. Returns read data combinationally in the same cycle.
- Stores pass through a small posted write buffer that drains into a word array through a single write port.
- The write port is shared with a debug/loader port, so the buffer can fill and back-pressure the pipeline.

---
 rtl/arm_dmem_pkg.sv | 30 +++
 rtl/arm_dmem_responder_if.sv | 20 ++
 rtl/arm_dmem_wbuf.sv | 64 ++++++
 rtl/arm_dmem_responder.sv | 66 ++++++
 tb/tb_arm_dmem_responder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/arm_dmem_pkg.sv
// Shared types and lane helpers for the MEM-stage data-memory responder.
// Byte offset k of a word lives on bits [8k+7:8k] and is enabled by be[3-k].
package arm_dmem_pkg;

    localparam int DEF_MEM_WORDS = 4096;
    localparam int AW            = $clog2(DEF_MEM_WORDS);
    localparam int DEF_WB_DEPTH  = 4;

    typedef struct packed {
        logic [AW-1:0] idx;
        logic [3:0]    be;
        logic [31:0]   data;
    } wbuf_entry_t;

    function automatic logic lane_of(input logic [3:0] be, input logic [1:0] k);
        return be[2'd3 - k];
    endfunction

    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] r;
        r = old_word;
        for (int k = 0; k < 4; k++) begin
            if (lane_of(be, 2'(k))) r[8*k +: 8] = new_word[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/arm_dmem_responder_if.sv
// MEM-stage data port: word address, byte-lane store and same-cycle read data.
interface arm_dmem_responder_if;

    logic [29:0] mem_addr;
    logic [3:0]  mem_write_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        mem_stall;

    modport master (
        output mem_addr, mem_write_en, mem_data_in,
        input  mem_data_out, mem_stall
    );

    modport slave (
        input  mem_addr, mem_write_en, mem_data_in,
        output mem_data_out, mem_stall
    );

endinterface

// File: rtl/arm_dmem_wbuf.sv
// Posted write buffer: circular FIFO plus a read port that overlays every
// pending entry for a word onto its array value, oldest first.
module arm_dmem_wbuf
    import arm_dmem_pkg::*;
#(
    parameter  int DEPTH = DEF_WB_DEPTH,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          push,
    input  wbuf_entry_t   push_entry,
    input  logic          pop,
    output wbuf_entry_t   head_entry,
    output logic [CW-1:0] count,
    output logic          full,
    input  logic [AW-1:0] rd_idx,
    input  logic [31:0]   rd_base,
    output logic [31:0]   rd_data
);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] slot;
    wbuf_entry_t   entries [DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: entry storage has no reset; validity is carried entirely by head/count.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= push_entry;
    end

    assign full       = (count == CW'(DEPTH));
    assign head_entry = entries[head];

    // NOTE: every variable assigned here gets a default first, so no latch is inferred.
    always_comb begin
        rd_data = rd_base;
        slot    = head;
        for (int i = 0; i < DEPTH; i++) begin
            slot = head + PW'(i);
            if (CW'(i) < count && entries[slot].idx == rd_idx)
                rd_data = merge_word(rd_data, entries[slot].data, entries[slot].be);
        end
    end

endmodule

// File: rtl/arm_dmem_responder.sv
// Data-memory responder: word array behind a posted write buffer, with a
// debug/loader port that wins the single array write port.
module arm_dmem_responder
    import arm_dmem_pkg::*;
#(
    parameter  int MEM_WORDS = DEF_MEM_WORDS,
    parameter  int WB_DEPTH  = DEF_WB_DEPTH,
    localparam int CW        = $clog2(WB_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_b,
    arm_dmem_responder_if.slave   mem,
    input  logic                  dbg_we,
    input  logic [AW-1:0]         dbg_addr,
    input  logic [31:0]           dbg_wdata,
    output logic [31:0]           dbg_rdata,
    output logic [CW-1:0]         wb_count,
    output logic                  wb_empty
);

    logic [31:0]   array [MEM_WORDS];
    logic [AW-1:0] idx;
    logic          store_req;
    logic          wb_full;
    logic          drain;
    logic          push;
    wbuf_entry_t   push_entry;
    wbuf_entry_t   head_entry;
    logic          unused_addr_hi;

    // Upper address bits are dropped on purpose: the array aliases across them.
    assign idx            = mem.mem_addr[AW-1:0];
    assign unused_addr_hi = ^mem.mem_addr[29:AW];

    assign store_req     = |mem.mem_write_en;
    assign drain         = (wb_count != '0) && !dbg_we;
    assign mem.mem_stall = store_req && wb_full && dbg_we;
    assign push          = store_req && !mem.mem_stall;
    assign push_entry    = '{idx: idx, be: mem.mem_write_en, data: mem.mem_data_in};
    assign wb_empty      = (wb_count == '0);

    arm_dmem_wbuf #(.DEPTH(WB_DEPTH)) u_wbuf (
        .clk        (clk),
        .rst_b      (rst_b),
        .push       (push),
        .push_entry (push_entry),
        .pop        (drain),
        .head_entry (head_entry),
        .count      (wb_count),
        .full       (wb_full),
        .rd_idx     (idx),
        .rd_base    (array[idx]),
        .rd_data    (mem.mem_data_out)
    );

    // Debug writes are full words and block the drain for that cycle.
    always_ff @(posedge clk) begin
        if (dbg_we)
            array[dbg_addr] <= dbg_wdata;
        else if (drain)
            array[head_entry.idx] <= merge_word(array[head_entry.idx], head_entry.data, head_entry.be);
    end

    assign dbg_rdata = array[dbg_addr];

endmodule

// File: tb/tb_arm_dmem_responder.sv
// Self-checking bench for arm_dmem_responder: read values go through a
// scoreboard queue, status outputs are compared directly.
module tb_arm_dmem_responder;
    import arm_dmem_pkg::*;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic [31:0]   dbg_rdata;
    logic [2:0]    wb_count;
    logic          wb_empty;

    arm_dmem_responder_if bus ();

    arm_dmem_responder dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .mem       (bus),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata),
        .wb_count  (wb_count),
        .wb_empty  (wb_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sbq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_expect(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sbq.push_back(it);
    endtask

    task automatic sb_compare(input logic [31:0] got);
        sb_item_t it;
        if (sbq.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            it = sbq.pop_front();
            check(it.tag, got, it.exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.mem_addr     = '0;
        bus.mem_write_en = '0;
        bus.mem_data_in  = '0;
        dbg_we           = 1'b0;
        dbg_addr         = '0;
        dbg_wdata        = '0;
    endtask

    task automatic store(input logic [29:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.mem_addr     = a;
        bus.mem_write_en = be;
        bus.mem_data_in  = d;
    endtask

    task automatic expect_read(input string tag, input logic [29:0] a, input logic [31:0] e);
        bus.mem_addr = a;
        sb_expect(tag, e);
        #1;
        sb_compare(bus.mem_data_out);
    endtask

    task automatic expect_raw(input string tag, input int i, input logic [31:0] e);
        dbg_addr = AW'(i);
        #1;
        check(tag, dbg_rdata, e);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && wb_empty !== 1'b1; i++) cyc();
        check(tag, {31'd0, wb_empty}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #12;
        check("rst_count", {29'd0, wb_count}, 32'd0);
        check("rst_empty", {31'd0, wb_empty}, 32'd1);
        check("rst_stall", {31'd0, bus.mem_stall}, 32'd0);
        rst_b = 1'b1;
        cyc();

        // Debug write then plain read with the buffer empty
        dbg_we = 1'b1; dbg_addr = 12'd5; dbg_wdata = 32'h11223344;
        cyc();
        dbg_we = 1'b0;
        expect_read("t1_read", 30'd5, 32'h11223344);

        // Byte store at offset 1, visible only from the next cycle
        store(30'd5, 4'b0100, 32'hAAAAAAAA);
        expect_read("t2_same_cycle", 30'd5, 32'h11223344);
        cyc();
        bus.mem_write_en = 4'b0000;
        check("t2_count", {29'd0, wb_count}, 32'd1);
        expect_read("t2_merged", 30'd5, 32'h1122AA44);
        expect_raw("t2_raw_before", 5, 32'h11223344);
        cyc();
        check("t2_empty", {31'd0, wb_empty}, 32'd1);
        expect_raw("t2_raw_after", 5, 32'h1122AA44);

        // Fill to FULL under a held debug write, then stall
        dbg_we = 1'b1; dbg_addr = 12'd100; dbg_wdata = 32'hDEAD0000;
        for (int c = 0; c < 6; c++) begin
            store(30'((c < 4) ? c : 4), 4'b1111, 32'((c < 4) ? c + 1 : 5));
            #1;
            check($sformatf("t3_stall_%0d", c), {31'd0, bus.mem_stall}, (c >= 4) ? 32'd1 : 32'd0);
            check($sformatf("t3_count_%0d", c), {29'd0, wb_count}, 32'((c < 4) ? c : 4));
            cyc();
        end
        dbg_we = 1'b0;
        #1;
        check("t3_accept", {31'd0, bus.mem_stall}, 32'd0);
        cyc();
        bus.mem_write_en = 4'b0000;
        check("t3_push_pop", {29'd0, wb_count}, 32'd4);
        wait_drain("t3_drain");
        for (int i = 0; i < 5; i++) expect_raw($sformatf("t3_word_%0d", i), i, 32'(i + 1));
        expect_raw("t3_dbg_word", 100, 32'hDEAD0000);
        expect_read("t3_read2", 30'd2, 32'd3);

        // Two lane stores to word 7 held in the buffer, then a debug write under them
        dbg_we = 1'b1; dbg_addr = 12'd7; dbg_wdata = 32'h55667788;
        cyc();
        dbg_addr = 12'd9; dbg_wdata = 32'h0;
        store(30'd7, 4'b1000, 32'h000000EE);
        cyc();
        store(30'd7, 4'b0001, 32'hDD000000);
        cyc();
        bus.mem_write_en = 4'b0000;
        dbg_addr = 12'd7; dbg_wdata = 32'h01020304;
        check("t4_count", {29'd0, wb_count}, 32'd2);
        expect_read("t4_merged", 30'd7, 32'hDD6677EE);
        cyc();
        dbg_we = 1'b0;
        expect_read("t4_over_dbg", 30'd7, 32'hDD0203EE);
        wait_drain("t4_drain");
        expect_raw("t4_array", 7, 32'hDD0203EE);

        // Reset with three pending entries discards them
        dbg_we = 1'b1;
        for (int i = 20; i < 23; i++) begin
            dbg_addr = AW'(i); dbg_wdata = 32'hA5000000 | 32'(i);
            cyc();
        end
        dbg_addr = 12'd30; dbg_wdata = 32'h0;
        for (int i = 20; i < 23; i++) begin
            store(30'(i), 4'b1111, 32'hFFFFFFFF);
            cyc();
        end
        bus.mem_write_en = 4'b0000;
        check("t5_count_pre", {29'd0, wb_count}, 32'd3);
        #2;
        rst_b = 1'b0;
        dbg_we = 1'b0;
        #1;
        check("t5_count_rst", {29'd0, wb_count}, 32'd0);
        check("t5_empty_rst", {31'd0, wb_empty}, 32'd1);
        #1;
        rst_b = 1'b1;
        cyc(); cyc(); cyc();
        for (int i = 20; i < 23; i++)
            expect_raw($sformatf("t5_word_%0d", i), i, 32'hA5000000 | 32'(i));

        // Upper address bits alias onto the same word
        store(30'h3FFFF005, 4'b1111, 32'hCAFEF00D);
        cyc();
        bus.mem_write_en = 4'b0000;
        expect_read("t6_alias_pending", 30'h0000005, 32'hCAFEF00D);
        wait_drain("t6_drain");
        expect_raw("t6_array", 5, 32'hCAFEF00D);
        expect_read("t6_alias_read", 30'h3FFFF005, 32'hCAFEF00D);

        check("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
